// File: rtl/pc_redirect_unit.sv
// Fetch-PC sequencer: resolves EX-stage branches/jumps into a fetch redirect,
// squashes younger instructions for FLUSH_CYCLES, and traps on misaligned targets.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_valid_i,
    input  logic        ex_is_br_i,
    input  logic        ex_is_jal_i,
    input  logic        ex_is_jalr_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_imm_i,
    input  logic [31:0] rs1_i,
    input  logic        br_less_i,
    input  logic        br_equal_i,
    input  logic        stall_i,
    output logic        br_unsign_o,
    output logic [31:0] pc_o,
    output logic        redirect_o,
    output logic        flush_o,
    output logic        misalign_o,
    output logic [15:0] taken_cnt_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_TRAP  = 2'd2;
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic lt, input logic eq);
        logic t;
        case (f3)
            3'b000:  t = eq;
            3'b001:  t = ~eq;
            3'b100:  t = lt;
            3'b101:  t = ~lt;
            3'b110:  t = lt;
            3'b111:  t = ~lt;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        flush_q, flush_d;
    logic        misalign_q, misalign_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;

    logic [31:0] target;
    logic [31:0] pc_seq;
    logic        take;
    logic        redirect_int;

    always_comb begin
        if (ex_is_jalr_i) begin
            target = (rs1_i + ex_imm_i) & ~32'd1;
        end else begin
            target = ex_pc_i + ex_imm_i;
        end
        pc_seq       = stall_i ? pc_q : pc_q + 32'd4;
        take         = ex_valid_i & (state_q == ST_RUN) &
                       (ex_is_jal_i | ex_is_jalr_i |
                        (ex_is_br_i & br_taken(ex_funct3_i, br_less_i, br_equal_i)));
        redirect_int = take & ~target[1];
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_cnt_d = flush_cnt_q;
        flush_d     = flush_q;
        misalign_d  = misalign_q;
        taken_cnt_d = taken_cnt_q;
        case (state_q)
            ST_RUN: begin
                // A redirect wins over stall: the new target must be fetched regardless.
                if (redirect_int) begin
                    pc_d        = target;
                    flush_cnt_d = FLUSH_INIT;
                    flush_d     = 1'b1;
                    taken_cnt_d = sat_inc(taken_cnt_q);
                    state_d     = ST_FLUSH;
                end else if (take) begin
                    misalign_d = 1'b1;
                    flush_d    = 1'b1;
                    state_d    = ST_TRAP;
                end else begin
                    pc_d = pc_seq;
                end
            end
            ST_FLUSH: begin
                pc_d = pc_seq;
                if (!stall_i) begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q == 3'd1) begin
                        flush_d = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_TRAP: begin
                flush_d    = 1'b1;
                misalign_d = 1'b1;
            end
            default: begin
                flush_d = 1'b0;
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            flush_cnt_q <= 3'd0;
            flush_q     <= 1'b0;
            misalign_q  <= 1'b0;
            taken_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_cnt_q <= flush_cnt_d;
            flush_q     <= flush_d;
            misalign_q  <= misalign_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_unsign_o = ex_funct3_i[1];
    assign pc_o        = pc_q;
    assign redirect_o  = rst_ni & redirect_int;
    assign flush_o     = flush_q;
    assign misalign_o  = misalign_q;
    assign taken_cnt_o = taken_cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with hand-computed expectations.
module tb_pc_redirect_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ex_valid_i, ex_is_br_i, ex_is_jal_i, ex_is_jalr_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_pc_i, ex_imm_i, rs1_i;
    logic        br_less_i, br_equal_i, stall_i;
    logic        br_unsign_o, redirect_o, flush_o, misalign_o;
    logic [31:0] pc_o;
    logic [15:0] taken_cnt_o;

    int checks = 0;
    int errors = 0;

    pc_redirect_unit #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .ex_is_br_i(ex_is_br_i), .ex_is_jal_i(ex_is_jal_i),
        .ex_is_jalr_i(ex_is_jalr_i), .ex_funct3_i(ex_funct3_i),
        .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i), .rs1_i(rs1_i),
        .br_less_i(br_less_i), .br_equal_i(br_equal_i), .stall_i(stall_i),
        .br_unsign_o(br_unsign_o), .pc_o(pc_o), .redirect_o(redirect_o),
        .flush_o(flush_o), .misalign_o(misalign_o), .taken_cnt_o(taken_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        ex_valid_i = 1'b0; ex_is_br_i = 1'b0; ex_is_jal_i = 1'b0; ex_is_jalr_i = 1'b0;
        ex_funct3_i = 3'b000; br_less_i = 1'b0; br_equal_i = 1'b0; stall_i = 1'b0;
        ex_pc_i = 32'd0; ex_imm_i = 32'd0; rs1_i = 32'd0;
    endtask

    task automatic branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                          input logic lt, input logic eq);
        idle();
        ex_valid_i = 1'b1; ex_is_br_i = 1'b1; ex_funct3_i = f3;
        ex_pc_i = pc; ex_imm_i = imm; br_less_i = lt; br_equal_i = eq;
        #1;
    endtask

    task automatic jal(input logic [31:0] pc, input logic [31:0] imm);
        idle();
        ex_valid_i = 1'b1; ex_is_jal_i = 1'b1; ex_pc_i = pc; ex_imm_i = imm;
        #1;
    endtask

    task automatic jalr(input logic [31:0] rs1, input logic [31:0] imm);
        idle();
        ex_valid_i = 1'b1; ex_is_jalr_i = 1'b1; rs1_i = rs1; ex_imm_i = imm;
        #1;
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
        ex_valid_i = 1'b1; ex_is_jal_i = 1'b1;
        #3;
        chk("rst_pc", pc_o, 32'h0);
        chkb("rst_flush", flush_o, 1'b0);
        chkb("rst_misalign", misalign_o, 1'b0);
        chk("rst_cnt", 32'(taken_cnt_o), 32'd0);
        chkb("rst_redirect_gated", redirect_o, 1'b0);
        idle();
        #9 rst_ni = 1'b1;

        step(); chk("seq_pc1", pc_o, 32'h4);
        step(); chk("seq_pc2", pc_o, 32'h8);
        step(); chk("seq_pc3", pc_o, 32'hC);
        chkb("seq_flush", flush_o, 1'b0);

        branch(3'b000, 32'h100, 32'h40, 1'b0, 1'b1);
        chkb("beq_redirect", redirect_o, 1'b1);
        chkb("beq_unsign", br_unsign_o, 1'b0);
        step(); idle(); #1;
        chk("beq_pc", pc_o, 32'h140);
        chkb("beq_flush1", flush_o, 1'b1);
        chk("beq_cnt", 32'(taken_cnt_o), 32'd1);
        chkb("beq_pulse_end", redirect_o, 1'b0);
        step(); chk("beq_pc_f2", pc_o, 32'h144); chkb("beq_flush2", flush_o, 1'b1);
        step(); chk("beq_pc_f3", pc_o, 32'h148); chkb("beq_flush_done", flush_o, 1'b0);

        branch(3'b000, 32'h100, 32'h40, 1'b0, 1'b0);
        chkb("beq_nt_redirect", redirect_o, 1'b0);
        step(); chk("beq_nt_pc", pc_o, 32'h14C); chk("beq_nt_cnt", 32'(taken_cnt_o), 32'd1);

        idle(); ex_valid_i = 1'b1; br_less_i = 1'b1; br_equal_i = 1'b1; ex_imm_i = 32'h80; #1;
        chkb("nonctl_redirect", redirect_o, 1'b0);
        step(); chk("nonctl_pc", pc_o, 32'h150);

        branch(3'b010, 32'h100, 32'h40, 1'b1, 1'b1);
        chkb("f010_never", redirect_o, 1'b0);
        step(); chk("f010_pc", pc_o, 32'h154);

        branch(3'b110, 32'h200, 32'h10, 1'b1, 1'b0);
        chkb("bltu_unsign", br_unsign_o, 1'b1);
        chkb("bltu_redirect", redirect_o, 1'b1);
        step(); idle();
        chk("bltu_pc", pc_o, 32'h210); chk("bltu_cnt", 32'(taken_cnt_o), 32'd2);
        step(); step();
        chk("bltu_pc_after", pc_o, 32'h218); chkb("bltu_flush_done", flush_o, 1'b0);

        branch(3'b100, 32'h300, 32'hFFFF_FF00, 1'b1, 1'b0);
        chkb("blt_unsign", br_unsign_o, 1'b0);
        chkb("blt_redirect", redirect_o, 1'b1);
        step(); idle();
        chk("blt_pc", pc_o, 32'h200); chk("blt_cnt", 32'(taken_cnt_o), 32'd3);
        step(); step();
        chk("blt_pc_after", pc_o, 32'h208);

        branch(3'b001, 32'h400, 32'h8, 1'b0, 1'b0);
        stall_i = 1'b1; #1;
        chkb("bne_stall_redirect", redirect_o, 1'b1);
        step();
        chk("bne_pc", pc_o, 32'h408); chkb("bne_flush1", flush_o, 1'b1);
        chk("bne_cnt", 32'(taken_cnt_o), 32'd4);
        idle(); stall_i = 1'b1;
        step();
        chk("flush_stall_pc", pc_o, 32'h408); chkb("flush_stall_flush", flush_o, 1'b1);
        jal(32'h800, 32'h0);
        chkb("flush_jal_ignored", redirect_o, 1'b0);
        step(); idle();
        chk("flush_jal_pc", pc_o, 32'h40C); chkb("flush_ext", flush_o, 1'b1);
        step();
        chk("flush_end_pc", pc_o, 32'h410); chkb("flush_end", flush_o, 1'b0);
        chk("flush_cnt", 32'(taken_cnt_o), 32'd4);

        jalr(32'h2001, 32'h4);
        chkb("jalr_redirect", redirect_o, 1'b1);
        step(); idle();
        chk("jalr_pc", pc_o, 32'h2004); chk("jalr_cnt", 32'(taken_cnt_o), 32'd5);
        step(); step();
        chk("jalr_pc_after", pc_o, 32'h200C);

        force dut.taken_cnt_q = 16'hFFFE;
        #1 release dut.taken_cnt_q;
        #1 chk("preload_cnt", 32'(taken_cnt_o), 32'h0000_FFFE);
        jal(32'h0, 32'hFFFF_FFFC);
        chkb("wrap_jal_redirect", redirect_o, 1'b1);
        step(); idle();
        chk("wrap_pc_top", pc_o, 32'hFFFF_FFFC); chk("sat_cnt1", 32'(taken_cnt_o), 32'h0000_FFFF);
        step(); chk("wrap_pc_zero", pc_o, 32'h0);
        step(); chk("wrap_pc_4", pc_o, 32'h4);
        jal(32'h10, 32'h0);
        step(); idle();
        chk("sat_pc", pc_o, 32'h10); chk("sat_cnt2", 32'(taken_cnt_o), 32'h0000_FFFF);
        step(); step();
        chk("sat_pc_after", pc_o, 32'h18);

        jalr(32'h2002, 32'h0);
        chkb("trap_no_redirect", redirect_o, 1'b0);
        step(); idle();
        chk("trap_pc", pc_o, 32'h18); chkb("trap_misalign", misalign_o, 1'b1);
        chkb("trap_flush", flush_o, 1'b1);
        jal(32'h500, 32'h0);
        chkb("trap_jal_ignored", redirect_o, 1'b0);
        step(); step(); idle();
        chk("trap_pc_frozen", pc_o, 32'h18); chkb("trap_misalign_sticky", misalign_o, 1'b1);
        chk("trap_cnt", 32'(taken_cnt_o), 32'h0000_FFFF);
        rst_ni = 1'b0; #1;
        chk("trap_rst_pc", pc_o, 32'h0); chkb("trap_rst_misalign", misalign_o, 1'b0);
        chkb("trap_rst_flush", flush_o, 1'b0); chk("trap_rst_cnt", 32'(taken_cnt_o), 32'd0);
        rst_ni = 1'b1;
        step(); chk("trap_rst_pc4", pc_o, 32'h4);

        jal(32'h100, 32'h0);
        step(); idle();
        chk("midflush_pc", pc_o, 32'h100); chkb("midflush_flush", flush_o, 1'b1);
        rst_ni = 1'b0; #1;
        chk("midflush_rst_pc", pc_o, 32'h0); chkb("midflush_rst_flush", flush_o, 1'b0);
        rst_ni = 1'b1;
        step();
        chk("midflush_pc4", pc_o, 32'h4); chkb("midflush_flush_off", flush_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
